// File: rtl/vvalu_ctrl.sv
// Issue controller for the vector ALU: accepts one instruction, drives the ALU and
// register-file addresses, and pulses writeback after the selected unit's latency.
// Optional: define VVALU_CTRL_PERFCNT_EN to add the perf_issued/perf_busy counters.
module vvalu_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int ADDSUB_LAT = 1,
  parameter int MULT_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_opcode,
  input  logic [ADDR_WIDTH-1:0] instr_rx,
  input  logic [ADDR_WIDTH-1:0] instr_ry,
  input  logic [ADDR_WIDTH-1:0] instr_dst,
  output logic [3:0]            alu_opcode,
  output logic [ADDR_WIDTH-1:0] rf_rx_addr,
  output logic [ADDR_WIDTH-1:0] rf_ry_addr,
  output logic                  wb_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  busy,
  output logic [1:0]            dbg_state
`ifdef VVALU_CTRL_PERFCNT_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_busy
`endif
);

  // outsel encodings of opcode[3:2]
  localparam logic [1:0] VVALU_SEL_OPY    = 2'b00;
  localparam logic [1:0] VVALU_SEL_ADDSUB = 2'b01;
  localparam logic [1:0] VVALU_SEL_MULT   = 2'b10;
  localparam logic [1:0] VVALU_SEL_RELU   = 2'b11;

  localparam int MAX_LAT = (ADDSUB_LAT > MULT_LAT) ? ADDSUB_LAT : MULT_LAT;
  localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              op_q;
  logic [ADDR_WIDTH-1:0]   rx_q, ry_q, dst_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wb_en_q;
  logic [CNT_W-1:0]        in_lat, op_lat;

  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] sel);
    case (sel)
      VVALU_SEL_ADDSUB: lat_of = CNT_W'(ADDSUB_LAT);
      VVALU_SEL_MULT:   lat_of = CNT_W'(MULT_LAT);
      VVALU_SEL_OPY,
      VVALU_SEL_RELU:   lat_of = '0;
      default:          lat_of = '0;
    endcase
  endfunction

  assign in_lat = lat_of(instr_opcode[3:2]);
  assign op_lat = lat_of(op_q[3:2]);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE, valid is ignored elsewhere.
  // wb_en is registered, so it is set one edge ahead of the cycle it must be high in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      wb_en_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wb_en_q <= 1'b0;
          if (instr_valid) begin
            op_q    <= instr_opcode;
            rx_q    <= instr_rx;
            ry_q    <= instr_ry;
            dst_q   <= instr_dst;
            wb_en_q <= (in_lat == '0);
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_lat == '0) begin
            wb_en_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= op_lat;
            wb_en_q <= (op_lat == CNT_W'(1));
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            wb_en_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wb_en_q <= ({1'b0, cnt_q} == (CNT_W + 1)'(2));
          end
        end
        default: begin
          wb_en_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_opcode  = op_q;
  assign rf_rx_addr  = rx_q;
  assign rf_ry_addr  = ry_q;
  assign wb_addr     = dst_q;
  assign wb_en       = wb_en_q;
  assign dbg_state   = state_q;

`ifdef VVALU_CTRL_PERFCNT_EN
  logic [31:0] perf_issued_q, perf_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_busy_q   <= '0;
    end else begin
      if (instr_valid && (state_q == S_IDLE)) perf_issued_q <= perf_issued_q + 32'd1;
      if (state_q != S_IDLE)                  perf_busy_q   <= perf_busy_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_busy   = perf_busy_q;
`endif

endmodule

// File: doc/vvalu_ctrl.md
VVALU_CTRL -- requirements
Module: vvalu_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: register-file address width for rx/ry/destination fields.
REQ-002 Parameter ADDSUB_LAT, default 1: cycles from opcode presentation to valid adder-subtractor result.
REQ-003 Parameter MULT_LAT, default 3: cycles from opcode presentation to valid multiplier result.
REQ-004 clk  input  1  single clock; one clock, reset synchronous active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 instr_valid  input  1  instruction offered.
REQ-007 instr_ready  output  1  instruction accepted when both valid and ready are high at a rising edge.
REQ-008 instr_opcode  input  4  ALU opcode: [3:2] outsel, [1] add/sub, [0] operand-Q select.
REQ-009 instr_rx, instr_ry, instr_dst  input  ADDR_WIDTH each  source-X, source-Y and destination addresses.
REQ-010 alu_opcode  output  4  opcode driven to the ALU.
REQ-011 rf_rx_addr, rf_ry_addr  output  ADDR_WIDTH each  register-file read addresses feeding ALU opX/opY.
REQ-012 wb_en  output  1  ALU output valid; write it back this cycle.
REQ-013 wb_addr  output  ADDR_WIDTH  writeback destination.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, WAIT.
REQ-016 IDLE: instr_ready=1; on handshake, register opcode/rx/ry/dst and go to EXEC.
REQ-017 EXEC and WAIT: instr_ready=0; alu_opcode, rf_rx_addr, rf_ry_addr and wb_addr hold the registered values unchanged until the FSM returns to IDLE.
REQ-018 Latency L by outsel: VVALU_SEL_OPY=0, VVALU_SEL_RELU=0, VVALU_SEL_ADDSUB=ADDSUB_LAT, VVALU_SEL_MULT=MULT_LAT (encodings from vvalu.svh).
REQ-019 L=0: wb_en=1 during the EXEC cycle; next state IDLE.
REQ-020 L>0: EXEC loads a down-counter with L and moves to WAIT; WAIT decrements it each cycle; wb_en=1 in the WAIT cycle where the counter equals 1, then next state IDLE.
REQ-021 wb_en is a single-cycle pulse exactly L cycles after the EXEC cycle; exactly one pulse per accepted instruction.
REQ-022 Issue rate: one instruction per L+2 cycles, with instr_valid held high.
REQ-023 Counter width: clog2(max(ADDSUB_LAT,MULT_LAT)+1); no wrap-around is reachable.
REQ-024 In IDLE, alu_opcode is held at its last value and wb_en=0.
REQ-025 instr_valid is ignored outside IDLE; no instruction is lost or duplicated.

Reset
REQ-026 rst aborts any state, including mid-WAIT, and returns to IDLE at the next edge with no wb_en pulse for the aborted instruction.
REQ-027 Reset values: state=IDLE, instr_ready=1 (from the first cycle after reset), wb_en=0, busy=0, alu_opcode=0, rf_rx_addr=0, rf_ry_addr=0, wb_addr=0, counter=0.
REQ-028 rst has priority over a simultaneous handshake; that instruction is not accepted.

Configuration
REQ-029 Macro VVALU_CTRL_PERFCNT_EN, when defined: adds outputs perf_issued[31:0] and perf_busy[31:0]. perf_issued increments on every handshake. perf_busy increments every cycle busy=1. Both reset to 0 and wrap modulo 2^32.
REQ-030 When VVALU_CTRL_PERFCNT_EN is undefined: these ports and counters are absent, and all other behaviour is identical.

Verification
REQ-031 After reset, ADDSUB opcode 4'b0110 (sub, Ry), rx=2, ry=3, dst=5, handshake at edge 0 -> EXEC at cycle 1 with alu_opcode=0x6; wb_en=1 with wb_addr=5 at cycle 2 only.
REQ-032 MULT opcode, dst=7, accepted at edge 0 -> wb_en at cycle 4 only; instr_ready=0 for cycles 1-4; rf addresses stable throughout.
REQ-033 RELU then OPY back-to-back with instr_valid held high -> wb_en at cycles 1 and 3; instr_ready high at cycles 0 and 2 only.
REQ-034 MULT accepted, rst asserted at cycle 2 -> no wb_en; instr_ready=1 at cycle 3; all outputs at their reset values.
REQ-035 rst and handshake in the same cycle -> instruction dropped; busy stays 0.
REQ-036 With VVALU_CTRL_PERFCNT_EN defined, 3 ADDSUB instructions back-to-back -> perf_issued=3, perf_busy=6.
